// File: rtl/stim_harness_pkg.sv
// Shared types and helpers for the stimulus/observation harness: run states,
// stock Galois tap masks, the right-shift LFSR step and per-channel seed derivation.
package stim_harness_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } run_state_t;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h80200003;
   localparam logic [63:0] TAPS_64 = 64'hD800000000000000;

   // Operands are zero-extended to 64 bits; callers truncate back to their width.
   function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [63:0] taps);
      return (s >> 1) ^ (s[0] ? taps : 64'd0);
   endfunction

   function automatic logic [63:0] seed_of(input int unsigned i, input logic [63:0] base,
                                           input logic [63:0] step, input int unsigned width);
      logic [63:0] mask;
      logic [63:0] s;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      s    = (base + step * 64'(i)) & mask;
      return (s == 64'd0) ? 64'd1 : s;
   endfunction

endpackage

// File: rtl/stim_lfsr_ch.sv
// One Galois right-shift LFSR stimulus channel; load (seed) wins over advance.
// State is registered and drives the output directly, so there is no input-to-output path.
module stim_lfsr_ch import stim_harness_pkg::*; #(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   output logic [WIDTH-1:0] state
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SEED;
      end else if (load) begin
         state <= SEED;
      end else if (advance) begin
         state <= WIDTH'(lfsr_step(64'(state), 64'(TAPS)));
      end
   end

endmodule

// File: rtl/stim_harness_core.sv
// Run-controlled LFSR stimulus bank plus MISR compaction of a wide observed bus; outputs are registered, no backpressure.
// STIM_HARNESS_OBS_REG_EN inserts a register on obs_i before folding (MISR then compacts the previous cycle's bus).
module stim_harness_core import stim_harness_pkg::*; #(
   parameter int unsigned         NUM_CH     = 12,
   parameter int unsigned         CH_WIDTH   = 32,
   parameter logic [CH_WIDTH-1:0] CH_TAPS    = CH_WIDTH'(32'h80200003),
   parameter logic [63:0]         SEED_BASE  = 64'd3,
   parameter logic [63:0]         SEED_STEP  = 64'd2,
   parameter int unsigned         OBS_WIDTH  = 256,
   parameter int unsigned         SIG_WIDTH  = 32,
   parameter logic [SIG_WIDTH-1:0] SIG_TAPS  = SIG_WIDTH'(32'h80200003),
   parameter int unsigned         RUN_CYCLES = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         freeze,
   input  logic [OBS_WIDTH-1:0]         obs_i,
   output logic [NUM_CH*CH_WIDTH-1:0]   stim_o,
   output logic [SIG_WIDTH-1:0]         sig_o,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam int          NUM_SLICES  = (OBS_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam int          PAD_WIDTH   = NUM_SLICES * SIG_WIDTH;
   localparam bit          RUN_BOUNDED = (RUN_CYCLES != 0);
   localparam logic [31:0] LAST_CNT    = RUN_CYCLES - 1;

   run_state_t             cur_state;
   run_state_t             nxt_state;
   logic [31:0]            cnt;
   logic                   adv;
   logic [OBS_WIDTH-1:0]   obs_src;
   logic [PAD_WIDTH-1:0]   obs_pad;
   logic [SIG_WIDTH-1:0]   obs_fold;

   // start outranks freeze, so a restart is never swallowed by a held freeze.
   assign adv = (cur_state == RUN) && !freeze && !start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         IDLE: if (start) nxt_state = RUN;
         RUN: begin
            if (start) begin
               nxt_state = RUN;
            end else if (adv && RUN_BOUNDED && (cnt == LAST_CNT)) begin
               nxt_state = DONE;
            end
         end
         DONE: if (start) nxt_state = RUN;
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      case (cur_state)
         RUN:     busy_o = 1'b1;
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   // Wraps freely when RUN_CYCLES is 0; only the bounded run reads it for control.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= 32'd0;
      end else if (start) begin
         cnt <= 32'd0;
      end else if (adv) begin
         cnt <= cnt + 32'd1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      stim_lfsr_ch #(
         .WIDTH (CH_WIDTH),
         .TAPS  (CH_TAPS),
         .SEED  (CH_WIDTH'(seed_of(i, SEED_BASE, SEED_STEP, CH_WIDTH)))
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .load    (start),
         .advance (adv),
         .state   (stim_o[i*CH_WIDTH +: CH_WIDTH])
      );
   end

`ifdef STIM_HARNESS_OBS_REG_EN
   logic [OBS_WIDTH-1:0] obs_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         obs_q <= '0;
      end else begin
         obs_q <= obs_i;
      end
   end

   assign obs_src = obs_q;
`else
   assign obs_src = obs_i;
`endif

   // Last slice is zero-padded up to a whole SIG_WIDTH word before XOR folding.
   always_comb begin
      obs_pad  = PAD_WIDTH'(obs_src);
      obs_fold = '0;
      for (int k = 0; k < NUM_SLICES; k++) begin
         obs_fold = obs_fold ^ obs_pad[k*SIG_WIDTH +: SIG_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_o <= '0;
      end else if (start) begin
         sig_o <= '0;
      end else if (adv) begin
         sig_o <= SIG_WIDTH'(lfsr_step(64'(sig_o), 64'(SIG_TAPS))) ^ obs_fold;
      end
   end

endmodule
